// File: rtl/mmul_sim_if.sv
// Host-side word-serial port of the 256-bit modular multiplier: load strobes, start, readout and debug taps.
// master = host driving operands and strobes, slave = the multiplier engine.
interface mmul_sim_if;
    logic [15:0]  datain;
    logic         loada;
    logic         loadb;
    logic         loadp;
    logic         mmul_en;
    logic         outc;
    logic         outd;
    logic         outb;
    logic [15:0]  regcout;
    logic [15:0]  regdout;
    logic [15:0]  regbout;
    logic [1:0]   c_flag;
    logic         mmul_rdy;
    logic [256:0] regb257;
    logic [256:0] regc257;
    logic [256:0] regd257;

    modport master (
        output datain, loada, loadb, loadp, mmul_en, outc, outd, outb,
        input  regcout, regdout, regbout, c_flag, mmul_rdy,
        input  regb257, regc257, regd257
    );

    modport slave (
        input  datain, loada, loadb, loadp, mmul_en, outc, outd, outb,
        output regcout, regdout, regbout, c_flag, mmul_rdy,
        output regb257, regc257, regd257
    );
endinterface

// File: rtl/mmul_sim.sv
// C = (A*B) mod P, MSB-first interleaved shift-add; 256 iterations, done 256 cycles after the start edge.
// No backpressure: mmul_rdy low while running, and every strobe is ignored until it returns high.
// MMUL_DEBUG_PORTS_EN exposes full B/C/D on regb257/regc257/regd257, otherwise those ports read 0.
module mmul_sim (
    input  logic       clk,
    input  logic       rst,
    mmul_sim_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [255:0] a_q, a_d;
    logic [256:0] b_q, b_d;
    logic [256:0] c_q, c_d;
    logic [256:0] d_q, d_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [1:0]   flag_q, flag_d;

    logic [257:0] p_ext;
    logic [257:0] t_sum;
    logic [257:0] t_red1;
    logic [256:0] t_red2;
    logic         idle;

    assign idle = (state_q == ST_IDLE);

    // Word rotation for readout; bit 256 stays put so 16 strobes restore the register.
    function automatic logic [256:0] rot16(input logic [256:0] r);
        return {r[256], r[15:0], r[255:16]};
    endfunction

    // One iteration: 2C + A[i]*B is below 3P when C, B < P, so two conditional subtractions suffice.
    always_comb begin
        p_ext  = {1'b0, d_q};
        t_sum  = {c_q, 1'b0} + (a_q[cnt_q] ? {1'b0, b_q} : 258'd0);
        t_red1 = (t_sum >= p_ext) ? (t_sum - p_ext) : t_sum;
        t_red2 = (t_red1 >= p_ext) ? 257'(t_red1 - p_ext) : t_red1[256:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.mmul_en) begin
                    c_d = 257'd0;
                    if (d_q == 257'd0) begin
                        flag_d = 2'b10;
                    end else begin
                        flag_d  = 2'b00;
                        cnt_d   = 8'd255;
                        state_d = ST_RUN;
                    end
                end else if (bus.loada) begin
                    a_d    = {bus.datain, a_q[255:16]};
                    flag_d = 2'b00;
                end else if (bus.loadb) begin
                    b_d    = {b_q[256], bus.datain, b_q[255:16]};
                    flag_d = 2'b00;
                end else if (bus.loadp) begin
                    d_d    = {d_q[256], bus.datain, d_q[255:16]};
                    flag_d = 2'b00;
                end else begin
                    // Readout strobes are independent so all three registers can stream together.
                    if (bus.outc) c_d = rot16(c_q);
                    if (bus.outd) d_d = rot16(d_q);
                    if (bus.outb) b_d = rot16(b_q);
                end
            end
            ST_RUN: begin
                c_d = t_red2;
                if (cnt_q == 8'd0) begin
                    flag_d  = 2'b01;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            a_q     <= 256'd0;
            b_q     <= 257'd0;
            c_q     <= 257'd0;
            d_q     <= 257'd0;
            cnt_q   <= 8'd0;
            flag_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
        end
    end

    assign bus.regcout  = c_q[15:0];
    assign bus.regdout  = d_q[15:0];
    assign bus.regbout  = b_q[15:0];
    assign bus.c_flag   = flag_q;
    assign bus.mmul_rdy = idle;

`ifdef MMUL_DEBUG_PORTS_EN
    assign bus.regb257 = b_q;
    assign bus.regc257 = c_q;
    assign bus.regd257 = d_q;
`else
    assign bus.regb257 = 257'd0;
    assign bus.regc257 = 257'd0;
    assign bus.regd257 = 257'd0;
`endif

endmodule

// File: tb/tb_mmul_sim.sv
// Directed + randomized bench for mmul_sim; reference result is (A*B) mod P from wide arithmetic.
module tb_mmul_sim;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mmul_sim_if bus_if();
    mmul_sim dut (.clk(clk), .rst(rst_n), .bus(bus_if));

    int ncmp  = 0;
    int nfail = 0;

`ifdef MMUL_DEBUG_PORTS_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    localparam logic [255:0] P_FULL = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] A_FULL = 256'h32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7;
    localparam logic [255:0] B_FULL = 256'hBC3736A2_F4F6779C_59BDCEE3_6B692153_D0A9877C_C62A4740_02DF32E5_2139F0A0;

    task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] ref_mulmod(input logic [255:0] a, input logic [255:0] b,
                                                input logic [255:0] p);
        logic [511:0] prod;
        prod = {256'd0, a} * {256'd0, b};
        return 256'(prod % {256'd0, p});
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic clear_inputs();
        bus_if.datain  = 16'd0;
        bus_if.loada   = 1'b0;
        bus_if.loadb   = 1'b0;
        bus_if.loadp   = 1'b0;
        bus_if.mmul_en = 1'b0;
        bus_if.outc    = 1'b0;
        bus_if.outd    = 1'b0;
        bus_if.outb    = 1'b0;
    endtask

    // sel: 0 = A, 1 = B, 2 = P
    task automatic load_op(input int sel, input logic [255:0] v);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus_if.datain = v[i*16 +: 16];
            bus_if.loada  = (sel == 0);
            bus_if.loadb  = (sel == 1);
            bus_if.loadp  = (sel == 2);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    // Pulses start, reports whether busy right after the start edge and cycles until ready.
    task automatic start_run(output logic busy0, output int n);
        @(negedge clk);
        bus_if.mmul_en = 1'b1;
        @(negedge clk);
        bus_if.mmul_en = 1'b0;
        busy0 = ~bus_if.mmul_rdy;
        n = 0;
        while (!bus_if.mmul_rdy && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic readout(output logic [255:0] c, output logic [255:0] d, output logic [255:0] b);
        @(negedge clk);
        bus_if.outc = 1'b1;
        bus_if.outd = 1'b1;
        bus_if.outb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            c[i*16 +: 16] = bus_if.regcout;
            d[i*16 +: 16] = bus_if.regdout;
            b[i*16 +: 16] = bus_if.regbout;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic do_mul(input string tag, input logic [255:0] a, input logic [255:0] b,
                          input logic [255:0] p);
        logic         busy0;
        int           n;
        logic [255:0] rc, rd, rb, expc;
        expc = ref_mulmod(a, b, p);
        load_op(0, a);
        load_op(1, b);
        load_op(2, p);
        start_run(busy0, n);
        chk({tag, "_busy"}, 257'(busy0), 257'd1);
        chk({tag, "_lat"}, 257'(n), 257'd256);
        chk({tag, "_flag"}, 257'(bus_if.c_flag), 257'd1);
        chk({tag, "_c257"}, bus_if.regc257, DBG ? {1'b0, expc} : 257'd0);
        readout(rc, rd, rb);
        chk({tag, "_c"}, 257'(rc), 257'(expc));
        chk({tag, "_d"}, 257'(rd), 257'(p));
        chk({tag, "_b"}, 257'(rb), 257'(b));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         busy0;
        int           n;
        logic [255:0] rc, rd, rb, ra2, p, a, b;

        clear_inputs();
        #3;
        chk("rst_rdy", 257'(bus_if.mmul_rdy), 257'd1);
        chk("rst_flag", 257'(bus_if.c_flag), 257'd0);
        chk("rst_cout", 257'(bus_if.regcout), 257'd0);
        chk("rst_dout", 257'(bus_if.regdout), 257'd0);
        chk("rst_bout", 257'(bus_if.regbout), 257'd0);
        chk("rst_c257", bus_if.regc257, 257'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_mul("small", 256'd3, 256'd5, 256'd7);
        chk("small_c_const", 257'(ref_mulmod(256'd3, 256'd5, 256'd7)), 257'd1);

        load_op(0, 256'd9);
        chk("load_clr_flag", 257'(bus_if.c_flag), 257'd0);

        do_mul("full", A_FULL, B_FULL, P_FULL);
        readout(rc, rd, rb);
        chk("full_c_again", 257'(rc), 257'(ref_mulmod(A_FULL, B_FULL, P_FULL)));
        chk("full_d_again", 257'(rd), 257'(P_FULL));
        chk("full_b_again", 257'(rb), 257'(B_FULL));
        chk("full_d_w0", 257'(rd[15:0]), 257'h0FFFF);
        chk("full_d_w4", 257'(rd[79:64]), 257'h00000);
        chk("full_b_w0", 257'(rb[15:0]), 257'h0F0A0);

        // Zero modulus: C is nonzero from the previous run and must be cleared.
        load_op(2, 256'd0);
        @(negedge clk);
        bus_if.mmul_en = 1'b1;
        @(negedge clk);
        bus_if.mmul_en = 1'b0;
        chk("zp_rdy", 257'(bus_if.mmul_rdy), 257'd1);
        chk("zp_flag", 257'(bus_if.c_flag), 257'd2);
        @(negedge clk);
        chk("zp_rdy_hold", 257'(bus_if.mmul_rdy), 257'd1);
        readout(rc, rd, rb);
        chk("zp_c", 257'(rc), 257'd0);

        do_mul("a_zero", 256'd0, B_FULL, P_FULL);
        do_mul("a_one", 256'd1, P_FULL - 256'd1, P_FULL);
        chk("a_one_const", 257'(ref_mulmod(256'd1, P_FULL - 256'd1, P_FULL)), 257'(P_FULL - 256'd1));

        for (int k = 0; k < 4; k++) begin
            p = rand256();
            if (k == 1) p = {240'd0, p[15:0]};
            if (p == 256'd0) p = 256'd1;
            a = rand256();
            b = rand256() % p;
            do_mul($sformatf("rnd%0d", k), a, b, p);
        end

        // Lockout: strobes during RUN must neither restart nor disturb operands.
        load_op(0, A_FULL);
        load_op(1, B_FULL);
        load_op(2, P_FULL);
        @(negedge clk);
        bus_if.mmul_en = 1'b1;
        @(negedge clk);
        bus_if.mmul_en = 1'b0;
        n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
        end
        bus_if.datain  = 16'h1234;
        bus_if.loadb   = 1'b1;
        bus_if.loada   = 1'b1;
        bus_if.mmul_en = 1'b1;
        bus_if.outb    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n++;
        end
        clear_inputs();
        while (!bus_if.mmul_rdy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("lock_lat", 257'(n), 257'd257);
        chk("lock_flag", 257'(bus_if.c_flag), 257'd1);
        readout(rc, rd, rb);
        chk("lock_c", 257'(rc), 257'(ref_mulmod(A_FULL, B_FULL, P_FULL)));
        chk("lock_b", 257'(rb), 257'(B_FULL));

        // Abort mid-run via asynchronous reset.
        do_mul("pre_abort", A_FULL, B_FULL, P_FULL);
        @(negedge clk);
        bus_if.mmul_en = 1'b1;
        @(negedge clk);
        bus_if.mmul_en = 1'b0;
        for (int i = 0; i < 100; i++) @(negedge clk);
        chk("abort_busy", 257'(bus_if.mmul_rdy), 257'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_rdy", 257'(bus_if.mmul_rdy), 257'd1);
        chk("abort_flag", 257'(bus_if.c_flag), 257'd0);
        chk("abort_cout", 257'(bus_if.regcout), 257'd0);
        chk("abort_dout", 257'(bus_if.regdout), 257'd0);
        chk("abort_bout", 257'(bus_if.regbout), 257'd0);
        @(negedge clk);
        rst_n = 1'b1;
        readout(rc, rd, rb);
        chk("abort_c", 257'(rc), 257'd0);
        chk("abort_d", 257'(rd), 257'd0);
        chk("abort_b", 257'(rb), 257'd0);
        // A was cleared by reset, so a run with fresh B and P must give 0.
        load_op(1, 256'd5);
        load_op(2, 256'd7);
        start_run(busy0, n);
        chk("abort_a_lat", 257'(n), 257'd256);
        readout(ra2, rd, rb);
        chk("abort_a_zero", 257'(ra2), 257'd0);
        chk("abort_a_flag", 257'(bus_if.c_flag), 257'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
